// File: rtl/mor1kx_store_buffer_drain.sv
// Store buffer drain controller and data-bus arbiter: pops committed stores onto the bus and
// shares the port with loads under a starvation limit. Define MOR1KX_SB_ATOMIC_EN for atomic resolution.
module mor1kx_store_buffer_drain #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int STARVE_LIMIT         = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              sb_empty_i,
    output logic                              sb_read_o,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_dat_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_pc_i,
    input  logic [OPTION_OPERAND_WIDTH/8-1:0] sb_bsel_i,
    input  logic                              sb_atomic_i,
    input  logic                              ld_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   ld_adr_i,
    input  logic [OPTION_OPERAND_WIDTH/8-1:0] ld_bsel_i,
    output logic                              ld_ack_o,
    output logic                              ld_err_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   ld_dat_o,
    output logic                              dbus_req_o,
    output logic                              dbus_we_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   dbus_adr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   dbus_dat_o,
    output logic [OPTION_OPERAND_WIDTH/8-1:0] dbus_bsel_o,
    input  logic                              dbus_ack_i,
    input  logic                              dbus_err_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   dbus_dat_i,
    input  logic                              atomic_reserve_i,
    output logic                              atomic_fail_o,
    output logic                              store_err_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   store_err_pc_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   store_err_adr_o,
    output logic                              sb_drained_o
);
    localparam int W  = OPTION_OPERAND_WIDTH;
    localparam int BW = OPTION_OPERAND_WIDTH / 8;
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] STORE = 2'd2;
    localparam logic [1:0] LOAD  = 2'd3;

    logic [1:0]    state_r;
    logic [1:0]    state_next_s;
    logic [CW-1:0] starve_cnt_r;
    logic [W-1:0]  entry_adr_r;
    logic [W-1:0]  entry_dat_r;
    logic [W-1:0]  entry_pc_r;
    logic [BW-1:0] entry_bsel_r;
    logic          store_err_r;
    logic [W-1:0]  store_err_pc_r;
    logic [W-1:0]  store_err_adr_r;
    logic          load_sel_s;
    logic          atomic_skip_s;
    logic          bus_done_s;

    assign load_sel_s = ld_req_i & (sb_empty_i | (starve_cnt_r < LIMIT));
    assign bus_done_s = dbus_ack_i | dbus_err_i;

`ifdef MOR1KX_SB_ATOMIC_EN
    // A store-conditional whose reservation was lost never reaches the bus.
    assign atomic_skip_s = (state_r == FETCH) & sb_atomic_i & ~atomic_reserve_i;
`else
    logic unused_atomic_s;
    assign unused_atomic_s = sb_atomic_i ^ atomic_reserve_i;
    assign atomic_skip_s   = 1'b0;
`endif

    // Next-state selection for the drain/arbitration FSM
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (load_sel_s) begin
                    state_next_s = LOAD;
                end else if (!sb_empty_i) begin
                    state_next_s = FETCH;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FETCH: begin
                if (atomic_skip_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = STORE;
                end
            end
            STORE, LOAD: begin
                if (bus_done_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register and load-starvation counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            starve_cnt_r <= {CW{1'b0}};
        end else begin
            state_r <= state_next_s;
            if ((state_r == IDLE) && load_sel_s && !sb_empty_i && (starve_cnt_r != {CW{1'b1}})) begin
                starve_cnt_r <= starve_cnt_r + 1'b1;
            end else if ((state_r == FETCH) && (state_next_s == STORE)) begin
                starve_cnt_r <= {CW{1'b0}};
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end
    end

    // Capture the popped store buffer entry while its data is valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_adr_r  <= {W{1'b0}};
            entry_dat_r  <= {W{1'b0}};
            entry_pc_r   <= {W{1'b0}};
            entry_bsel_r <= {BW{1'b0}};
        end else if (state_r == FETCH) begin
            entry_adr_r  <= sb_adr_i;
            entry_dat_r  <= sb_dat_i;
            entry_pc_r   <= sb_pc_i;
            entry_bsel_r <= sb_bsel_i;
        end else begin
            entry_adr_r  <= entry_adr_r;
            entry_dat_r  <= entry_dat_r;
            entry_pc_r   <= entry_pc_r;
            entry_bsel_r <= entry_bsel_r;
        end
    end

    // Store bus-error pulse plus sticky PC/address of the faulting store
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_err_r     <= 1'b0;
            store_err_pc_r  <= {W{1'b0}};
            store_err_adr_r <= {W{1'b0}};
        end else if ((state_r == STORE) && dbus_err_i) begin
            store_err_r     <= 1'b1;
            store_err_pc_r  <= entry_pc_r;
            store_err_adr_r <= entry_adr_r;
        end else begin
            store_err_r     <= 1'b0;
            store_err_pc_r  <= store_err_pc_r;
            store_err_adr_r <= store_err_adr_r;
        end
    end

    assign store_err_o     = store_err_r;
    assign store_err_pc_o  = store_err_pc_r;
    assign store_err_adr_o = store_err_adr_r;
    assign atomic_fail_o   = atomic_skip_s;
    assign sb_drained_o    = (state_r == IDLE) & sb_empty_i;

    // Bus and LSU outputs decoded from state; error wins over a simultaneous ack
    always_comb begin
        sb_read_o   = 1'b0;
        ld_ack_o    = 1'b0;
        ld_err_o    = 1'b0;
        ld_dat_o    = {W{1'b0}};
        dbus_req_o  = 1'b0;
        dbus_we_o   = 1'b0;
        dbus_adr_o  = {W{1'b0}};
        dbus_dat_o  = {W{1'b0}};
        dbus_bsel_o = {BW{1'b0}};
        case (state_r)
            IDLE: begin
                sb_read_o = rst_n & ~sb_empty_i & ~load_sel_s;
            end
            STORE: begin
                dbus_req_o  = 1'b1;
                dbus_we_o   = 1'b1;
                dbus_adr_o  = entry_adr_r;
                dbus_dat_o  = entry_dat_r;
                dbus_bsel_o = entry_bsel_r;
            end
            LOAD: begin
                dbus_req_o  = 1'b1;
                dbus_adr_o  = ld_adr_i;
                dbus_bsel_o = ld_bsel_i;
                ld_err_o    = dbus_err_i;
                ld_ack_o    = dbus_ack_i & ~dbus_err_i;
                if (dbus_ack_i && !dbus_err_i) begin
                    ld_dat_o = dbus_dat_i;
                end else begin
                    ld_dat_o = {W{1'b0}};
                end
            end
            default: begin
                sb_read_o = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_mor1kx_store_buffer_drain.sv
// Self-checking bench: store buffer model, randomized bus slave and load driver against a queue-based reference.
module tb_mor1kx_store_buffer_drain;
    localparam int K = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0, sb_empty_i = 1'b1, sb_read_o, sb_atomic_i = 1'b0;
    logic [31:0] sb_adr_i = 32'd0, sb_dat_i = 32'd0, sb_pc_i = 32'd0;
    logic [3:0] sb_bsel_i = 4'd0, ld_bsel_i = 4'd0, dbus_bsel_o;
    logic ld_req_i = 1'b0, ld_ack_o, ld_err_o;
    logic [31:0] ld_adr_i = 32'd0, ld_dat_o, dbus_adr_o, dbus_dat_o, dbus_dat_i = 32'd0;
    logic dbus_req_o, dbus_we_o, dbus_ack_i = 1'b0, dbus_err_i = 1'b0;
    logic atomic_reserve_i = 1'b0, atomic_fail_o, store_err_o, sb_drained_o;
    logic [31:0] store_err_pc_o, store_err_adr_o;

    mor1kx_store_buffer_drain #(.OPTION_OPERAND_WIDTH(32), .STARVE_LIMIT(K)) dut (
        .clk(clk), .rst_n(rst_n), .sb_empty_i(sb_empty_i), .sb_read_o(sb_read_o),
        .sb_adr_i(sb_adr_i), .sb_dat_i(sb_dat_i), .sb_pc_i(sb_pc_i), .sb_bsel_i(sb_bsel_i),
        .sb_atomic_i(sb_atomic_i), .ld_req_i(ld_req_i), .ld_adr_i(ld_adr_i), .ld_bsel_i(ld_bsel_i),
        .ld_ack_o(ld_ack_o), .ld_err_o(ld_err_o), .ld_dat_o(ld_dat_o),
        .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_adr_o(dbus_adr_o),
        .dbus_dat_o(dbus_dat_o), .dbus_bsel_o(dbus_bsel_o), .dbus_ack_i(dbus_ack_i),
        .dbus_err_i(dbus_err_i), .dbus_dat_i(dbus_dat_i), .atomic_reserve_i(atomic_reserve_i),
        .atomic_fail_o(atomic_fail_o), .store_err_o(store_err_o), .store_err_pc_o(store_err_pc_o),
        .store_err_adr_o(store_err_adr_o), .sb_drained_o(sb_drained_o)
    );

    typedef struct { logic we; logic [31:0] adr; logic [31:0] dat; logic [3:0] bsel; } txn_t;
    typedef struct { logic [31:0] adr; logic [31:0] dat; logic [31:0] pc; logic [3:0] bsel; logic atomic; } ent_t;

    ent_t sbq[$];
    ent_t stage_q[$];
    txn_t bus_log[$];
    txn_t ld_exp[$];
    int checks = 0;
    int fails = 0;
    int fixed_wait = -1;
    bit inj_err = 1'b0;
    bit inj_both = 1'b0;
    bit pop_pend = 1'b0;

    function automatic ent_t rand_ent();
        ent_t e;
        e.adr = $urandom & 32'hFFFF_FFFC;
        e.dat = $urandom;
        e.pc = $urandom & 32'hFFFF_FFFC;
        e.bsel = 4'($urandom_range(1, 15));
        e.atomic = 1'b0;
        return e;
    endfunction

    task automatic push(input ent_t e);
        sbq.push_back(e);
        sb_empty_i = 1'b0;
    endtask

    // Store buffer model: a pop strobe makes the head entry visible during the following cycle
    initial forever begin
        @(negedge clk); #2;
        pop_pend = sb_read_o;
        @(posedge clk); #1;
        if (pop_pend && sbq.size() > 0) begin
            ent_t e;
            e = sbq.pop_front();
            sb_adr_i = e.adr; sb_dat_i = e.dat; sb_pc_i = e.pc; sb_bsel_i = e.bsel; sb_atomic_i = e.atomic;
        end
        pop_pend = 1'b0;
        sb_empty_i = (sbq.size() == 0);
    end

    // Bus slave: random wait states, logs each completed transaction, checks request stability
    initial begin
        bit busy;
        int waits;
        txn_t cap;
        busy = 1'b0; waits = 0;
        forever begin
            @(negedge clk);
            dbus_ack_i = 1'b0; dbus_err_i = 1'b0; dbus_dat_i = 32'd0;
            if (!dbus_req_o) begin
                busy = 1'b0;
            end else begin
                if (!busy) begin
                    busy = 1'b1;
                    cap.we = dbus_we_o; cap.adr = dbus_adr_o; cap.dat = dbus_dat_o; cap.bsel = dbus_bsel_o;
                    waits = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 2));
                end else begin
                    checks++;
                    if (dbus_we_o !== cap.we || dbus_adr_o !== cap.adr || dbus_dat_o !== cap.dat || dbus_bsel_o !== cap.bsel) begin
                        fails++;
                        $display("FAIL bus_stable: got we=%b adr=%h dat=%h bsel=%h, held we=%b adr=%h dat=%h bsel=%h",
                                 dbus_we_o, dbus_adr_o, dbus_dat_o, dbus_bsel_o, cap.we, cap.adr, cap.dat, cap.bsel);
                    end
                end
                if (waits == 0) begin
                    bus_log.push_back(cap);
                    busy = 1'b0;
                    if (inj_both) begin
                        dbus_ack_i = 1'b1; dbus_err_i = 1'b1; inj_both = 1'b0;
                    end else if (inj_err) begin
                        dbus_err_i = 1'b1; inj_err = 1'b0;
                    end else begin
                        dbus_ack_i = 1'b1;
                    end
                    if (!cap.we) dbus_dat_i = cap.adr ^ 32'hA5A5_5A5A;
                end else begin
                    waits--;
                end
            end
        end
    end

    task automatic wait_drain(input string name);
        int stable;
        stable = 0;
        for (int c = 0; c < 300 && stable < 3; c++) begin
            @(negedge clk); #1;
            if (sbq.size() == 0 && sb_drained_o === 1'b1 && dbus_req_o === 1'b0 && ld_req_i === 1'b0) stable++;
            else stable = 0;
        end
        checks++;
        if (stable < 3) begin
            fails++;
            $display("FAIL %s_drain_timeout: drained=%b queue=%0d, required drained within 300 cycles", name, sb_drained_o, sbq.size());
        end
    endtask

    // Issues n back-to-back loads with ld_req_i held high throughout; staged entries enter with the first request
    task automatic run_loads(input int n, input bit exp_err);
        for (int i = 0; i < n; i++) begin
            txn_t t;
            bit done;
            t.we = 1'b0; t.adr = $urandom & 32'hFFFF_FFFC; t.dat = 32'd0; t.bsel = 4'($urandom_range(1, 15));
            @(posedge clk); #2;
            ld_req_i = 1'b1; ld_adr_i = t.adr; ld_bsel_i = t.bsel;
            while (stage_q.size() > 0) push(stage_q.pop_front());
            ld_exp.push_back(t);
            done = 1'b0;
            for (int c = 0; c < 200 && !done; c++) begin
                @(negedge clk); #1;
                if (ld_ack_o === 1'b1 || ld_err_o === 1'b1) done = 1'b1;
            end
            checks++;
            if (!done) begin
                fails++;
                $display("FAIL load_timeout: no completion for adr=%h within 200 cycles", t.adr);
            end else if (exp_err) begin
                if (ld_err_o !== 1'b1 || ld_ack_o !== 1'b0) begin
                    fails++;
                    $display("FAIL load_err: got err=%b ack=%b, required err=1 ack=0", ld_err_o, ld_ack_o);
                end
            end else if (ld_ack_o !== 1'b1 || ld_err_o !== 1'b0 || ld_dat_o !== (t.adr ^ 32'hA5A5_5A5A)) begin
                fails++;
                $display("FAIL load_data: got ack=%b err=%b dat=%h, required ack=1 err=0 dat=%h",
                         ld_ack_o, ld_err_o, ld_dat_o, t.adr ^ 32'hA5A5_5A5A);
            end
        end
        @(posedge clk); #2;
        ld_req_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({dbus_req_o, dbus_we_o, sb_read_o, ld_ack_o, ld_err_o, store_err_o, atomic_fail_o} !== 7'd0 ||
            dbus_adr_o !== 32'd0 || dbus_dat_o !== 32'd0 || dbus_bsel_o !== 4'd0 || ld_dat_o !== 32'd0) begin
            fails++;
            $display("FAIL reset_outputs: req=%b we=%b rd=%b ack=%b err=%b serr=%b afail=%b adr=%h, required all 0",
                     dbus_req_o, dbus_we_o, sb_read_o, ld_ack_o, ld_err_o, store_err_o, atomic_fail_o, dbus_adr_o);
        end
        checks++;
        if (sb_drained_o !== 1'b1 || store_err_pc_o !== 32'd0 || store_err_adr_o !== 32'd0) begin
            fails++;
            $display("FAIL reset_drained: drained=%b pc=%h adr=%h, required 1/0/0", sb_drained_o, store_err_pc_o, store_err_adr_o);
        end
        sb_empty_i = 1'b0;
        #1;
        checks++;
        if (sb_read_o !== 1'b0 || sb_drained_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_nonempty: read=%b drained=%b, required 0/0", sb_read_o, sb_drained_o);
        end
        sb_empty_i = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_store();
        ent_t e;
        int rd, rq, ak, drn_ack, drn_after;
        e = rand_ent(); e.adr = 32'h100; e.dat = 32'hDEADBEEF; e.bsel = 4'hF;
        fixed_wait = 2; bus_log.delete();
        rd = -1; rq = -1; ak = -1; drn_ack = -1; drn_after = -1;
        @(posedge clk); #2;
        push(e);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); #1;
            if (sb_read_o === 1'b1 && rd < 0) rd = c;
            if (dbus_req_o === 1'b1 && rq < 0) rq = c;
            if (ak >= 0 && c == ak + 1) drn_after = int'(sb_drained_o);
            if (dbus_ack_i === 1'b1 && ak < 0) begin ak = c; drn_ack = int'(sb_drained_o); end
        end
        fixed_wait = -1;
        checks++;
        if (rd < 0 || rq - rd != 2) begin
            fails++; $display("FAIL store_latency: read at %0d req at %0d, required req 2 cycles after read", rd, rq);
        end
        checks++;
        if (ak - rq != 2) begin
            fails++; $display("FAIL store_wait: req at %0d ack at %0d, required 2 wait cycles", rq, ak);
        end
        checks++;
        if (drn_ack != 0 || drn_after != 1) begin
            fails++; $display("FAIL store_drained: at ack %0d after %0d, required 0 then 1", drn_ack, drn_after);
        end
        checks++;
        if (bus_log.size() != 1 || bus_log[0].we !== 1'b1 || bus_log[0].adr !== 32'h100 ||
            bus_log[0].dat !== 32'hDEADBEEF || bus_log[0].bsel !== 4'hF) begin
            fails++; $display("FAIL store_write: %0d txns first adr=%h, required one write 100/DEADBEEF/F", bus_log.size(),
                              (bus_log.size() > 0) ? bus_log[0].adr : 32'd0);
        end
    endtask

    task automatic test_store_error();
        ent_t e1, e2;
        int pulses;
        e1 = rand_ent(); e1.pc = 32'h2000; e1.adr = 32'h300;
        e2 = rand_ent();
        bus_log.delete(); pulses = 0;
        inj_err = 1'b1;
        @(posedge clk); #2;
        push(e1); push(e2);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk); #1;
            if (store_err_o === 1'b1) pulses++;
        end
        wait_drain("store_error");
        checks++;
        if (pulses != 1 || store_err_pc_o !== 32'h2000 || store_err_adr_o !== 32'h300) begin
            fails++; $display("FAIL store_err: pulses=%0d pc=%h adr=%h, required 1/00002000/00000300", pulses, store_err_pc_o, store_err_adr_o);
        end
        checks++;
        if (bus_log.size() != 2 || bus_log[1].we !== 1'b1 || bus_log[1].adr !== e2.adr || bus_log[1].dat !== e2.dat) begin
            fails++; $display("FAIL store_err_continue: %0d txns, required 2 with second write to %h", bus_log.size(), e2.adr);
        end
    endtask

    task automatic test_load_error();
        bus_log.delete(); ld_exp.delete();
        inj_both = 1'b1;
        run_loads(1, 1'b1);
        run_loads(3, 1'b0);
        checks++;
        if (bus_log.size() != 4) begin
            fails++; $display("FAIL load_count: %0d txns, required 4", bus_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (bus_log[i].we !== 1'b0 || bus_log[i].adr !== ld_exp[i].adr || bus_log[i].bsel !== ld_exp[i].bsel) begin
                    fails++; $display("FAIL load_bus[%0d]: we=%b adr=%h bsel=%h, required 0/%h/%h", i,
                                      bus_log[i].we, bus_log[i].adr, bus_log[i].bsel, ld_exp[i].adr, ld_exp[i].bsel);
                end
            end
        end
    endtask

    task automatic test_atomic();
        ent_t e;
        int fpulse;
        int exp_n;
        e = rand_ent(); e.atomic = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            bus_log.delete(); fpulse = 0;
            atomic_reserve_i = (pass == 1);
            @(posedge clk); #2;
            push(e);
            for (int c = 0; c < 20; c++) begin
                @(negedge clk); #1;
                if (atomic_fail_o === 1'b1) fpulse++;
            end
            wait_drain("atomic");
`ifdef MOR1KX_SB_ATOMIC_EN
            exp_n = (pass == 1) ? 1 : 0;
`else
            exp_n = 1;
`endif
            checks++;
            if (bus_log.size() != exp_n || fpulse != 1 - exp_n) begin
                fails++; $display("FAIL atomic_pass%0d: writes=%0d fail_pulses=%0d, required %0d/%0d", pass,
                                  bus_log.size(), fpulse, exp_n, 1 - exp_n);
            end
        end
        atomic_reserve_i = 1'b0;
    endtask

    task automatic test_reset_mid_store();
        bit seen;
        fixed_wait = 20; seen = 1'b0;
        @(posedge clk); #2;
        push(rand_ent());
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk); #1;
            if (dbus_req_o === 1'b1) seen = 1'b1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (!seen || dbus_req_o !== 1'b0) begin
            fails++; $display("FAIL reset_mid_store: seen=%b req=%b, required seen=1 req=0", seen, dbus_req_o);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fixed_wait = -1;
        @(negedge clk); #1;
        checks++;
        if (sb_drained_o !== 1'b1 || dbus_req_o !== 1'b0 || sb_read_o !== 1'b0) begin
            fails++; $display("FAIL reset_release: drained=%b req=%b read=%b, required 1/0/0", sb_drained_o, dbus_req_o, sb_read_o);
        end
    endtask

    // Held load requests against buffered stores: at most K loads between stores while stores wait
    task automatic test_starvation();
        ent_t ents[3];
        txn_t exp[$];
        int li, si, streak;
        bus_log.delete(); ld_exp.delete();
        for (int i = 0; i < 3; i++) begin
            ents[i] = rand_ent();
            stage_q.push_back(ents[i]);
        end
        run_loads(8, 1'b0);
        wait_drain("starvation");
        li = 0; si = 0; streak = 0;
        while (li < 8 || si < 3) begin
            if (li < 8 && (si >= 3 || streak < K)) begin
                exp.push_back(ld_exp[li]); li++;
                if (si < 3) streak++;
            end else begin
                txn_t t;
                t.we = 1'b1; t.adr = ents[si].adr; t.dat = ents[si].dat; t.bsel = ents[si].bsel;
                exp.push_back(t); si++; streak = 0;
            end
        end
        checks++;
        if (bus_log.size() != exp.size()) begin
            fails++; $display("FAIL starve_count: %0d txns, required %0d", bus_log.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (bus_log[i].we !== exp[i].we || bus_log[i].adr !== exp[i].adr || bus_log[i].bsel !== exp[i].bsel ||
                    (exp[i].we && bus_log[i].dat !== exp[i].dat)) begin
                    fails++; $display("FAIL starve_order[%0d]: we=%b adr=%h, required we=%b adr=%h", i,
                                      bus_log[i].we, bus_log[i].adr, exp[i].we, exp[i].adr);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        ent_t ents[$];
        bus_log.delete();
        @(posedge clk); #2;
        for (int i = 0; i < 6; i++) begin
            ents.push_back(rand_ent());
            push(ents[i]);
        end
        wait_drain("back_to_back");
        checks++;
        if (bus_log.size() != 6) begin
            fails++; $display("FAIL b2b_count: %0d writes, required 6", bus_log.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (bus_log[i].we !== 1'b1 || bus_log[i].adr !== ents[i].adr || bus_log[i].dat !== ents[i].dat ||
                    bus_log[i].bsel !== ents[i].bsel) begin
                    fails++; $display("FAIL b2b[%0d]: adr=%h dat=%h, required %h/%h", i,
                                      bus_log[i].adr, bus_log[i].dat, ents[i].adr, ents[i].dat);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_store();
        wait_drain("single_store");
        test_store_error();
        test_load_error();
        test_atomic();
        test_reset_mid_store();
        test_starvation();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
